// File: rtl/seven_seg_scan_if.sv
// Display bus for seven_seg_scan: digit content and controls in, anode/cathode pins and frame strobe out.
// The master side drives content; the slave side is the scanner.
interface seven_seg_scan_if #(
  parameter int DIGITS = 8
) ();
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blank;
  logic [3:0]          bright;
  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;
  logic                dp_n;
  logic                frame;

  modport master (
    output data, dp, blank, bright,
    input  an, seg, dp_n, frame
  );

  modport slave (
    input  data, dp, blank, bright,
    output an, seg, dp_n, frame
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Multiplexed common-anode seven-segment scanner with PWM brightness and frame-latched content.
// Optional leading-zero blanking is built when SEVEN_SEG_LZB_EN is defined.
//
// state    | meaning
// ST_PRIME | first clock after reset: load shadows, outputs stay dark
// ST_SCAN  | normal scanning, shadows reload at each frame wrap
module seven_seg_scan #(
  parameter int DIGITS = 8,
  parameter int DIV    = 1000
) (
  input  logic           clk,
  input  logic           rs,
  seven_seg_scan_if.slave bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_SCAN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] data_sh;
  logic [DIGITS-1:0]   dp_sh;
  logic [DIGITS-1:0]   blank_sh;
  logic [3:0]          bright_sh;

  logic [DIGITS-1:0]   an_q;
  logic [6:0]          seg_q;
  logic                dp_n_q;
  logic                frame_q;

  logic                last_cnt;
  logic                last_idx;
  logic                frame_wrap;
  logic                load_en;
  logic                scan_en;
  logic [31:0]         on_time;
  logic [DIGITS-1:0]   blank_eff;
  logic                active;
  logic [3:0]          nibble;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign last_cnt   = (cnt == CW'(DIV - 1));
  assign last_idx   = (idx == IW'(DIGITS - 1));
  assign frame_wrap = last_cnt && last_idx;

  always_ff @(posedge clk) begin
    if (rs) state <= ST_PRIME;
    else    state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    scan_en   = 1'b0;
    case (state)
      ST_PRIME: begin
        load_en   = 1'b1;
        state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        scan_en = 1'b1;
        load_en = frame_wrap;
      end
      default: state_nxt = ST_PRIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      cnt <= '0;
      idx <= '0;
    end else if (scan_en) begin
      cnt <= last_cnt ? '0 : cnt + CW'(1);
      if (last_cnt) idx <= last_idx ? '0 : idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      data_sh   <= '0;
      dp_sh     <= '0;
      blank_sh  <= '0;
      bright_sh <= '0;
    end else if (load_en) begin
      data_sh   <= bus.data;
      dp_sh     <= bus.dp;
      blank_sh  <= bus.blank;
      bright_sh <= bus.bright;
    end
  end

`ifdef SEVEN_SEG_LZB_EN
  // Shadows only change at frame wrap, so this mask is stable for a whole frame.
  logic [DIGITS-1:0] lz_mask;
  logic              lead;

  always_comb begin
    lz_mask = '0;
    lead    = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (data_sh[4*i +: 4] == 4'h0) && !dp_sh[i]) lz_mask[i] = 1'b1;
      else                                                  lead       = 1'b0;
    end
  end

  assign blank_eff = blank_sh | lz_mask;
`else
  assign blank_eff = blank_sh;
`endif

  // bright=15 yields exactly DIV, so the anode stays on for the whole slot.
  assign on_time = ((32'(bright_sh) + 32'd1) * 32'(DIV)) >> 4;
  assign nibble  = data_sh[4*idx +: 4];
  assign active  = (32'(cnt) < on_time) && !blank_eff[idx];

  always_ff @(posedge clk) begin
    if (rs || !scan_en) begin
      an_q    <= '1;
      seg_q   <= 7'h7F;
      dp_n_q  <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      an_q    <= active ? ~(DIGITS'(1) << idx) : '1;
      seg_q   <= active ? hex7(nibble) : 7'h7F;
      dp_n_q  <= active ? ~dp_sh[idx] : 1'b1;
      frame_q <= (cnt == '0) && (idx == '0);
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.dp_n  = dp_n_q;
  assign bus.frame = frame_q;

endmodule
